button_count_scan: RTL

Upstream stage of the 8-digit seven-segment display path. Debounces a raw push-button, counts presses in an 8-digit packed-BCD counter (0–99999999), and time-multiplexes the digits to the LED decoder. Each scan step presents one `enable` strobe with a digit index on `sidx` and a BCD code on `val`. Leading zeros are optionally blanked by emitting code 4'hF, which the decoder renders as all segments off.

---
 rtl/button_count_scan.sv | 135 +++++++++++++
 1 files changed

// File: rtl/button_count_scan.sv
// rtl/button_count_scan.sv - debounced press counter with 8-digit BCD scan output
module button_count_scan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_DIV        = 50000,
    parameter bit BLANK_LZ        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       clr,
    output logic       enable,
    output logic [3:0] val,
    output logic [2:0] sidx,
    output logic       count_wrap
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = $clog2(SCAN_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic [DB_W-1:0] stab_q, stab_d;
    logic            inc_q, inc_d;
    logic [31:0]     count_q, count_d;
    logic [31:0]     count_inc;
    logic            carry;
    logic            wrap_q, wrap_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic            presc_wrap;
    logic            enable_q, enable_d;
    logic [3:0]      val_q, val_d;
    logic [2:0]      sidx_q, sidx_d;
    logic [2:0]      msd;

    // Two-flop synchronizer, then debounce: db toggles only after the synced
    // input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db_d    = db_q;
        stab_d  = '0;
        if (sync2_q != db_q) begin
            if (stab_q == DB_LAST) begin
                db_d   = ~db_q;
                stab_d = '0;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
        inc_d = db_d & ~db_q;
    end

    // Decimal ripple increment; the carry out of the top nibble marks a wrap.
    always_comb begin
        carry     = inc_q;
        count_inc = count_q;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        count_d = clr ? 32'd0 : count_inc;
        wrap_d  = inc_q & carry & ~clr;
    end

    // Index of the most significant nonzero digit (0 when the count is zero).
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (count_q[4*i +: 4] != 4'd0) begin
                msd = 3'(i);
            end
        end
    end

    // Scan prescaler: each wrap advances the digit index and loads its code.
    always_comb begin
        presc_wrap = (presc_q == PS_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        enable_d   = presc_wrap;
        sidx_d     = sidx_q;
        val_d      = val_q;
        if (presc_wrap) begin
            sidx_d = sidx_q + 3'd1;
            if (BLANK_LZ && (sidx_d > msd)) begin
                val_d = 4'hF;
            end else begin
                val_d = count_q[{sidx_d, 2'b00} +: 4];
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            stab_q   <= '0;
            inc_q    <= 1'b0;
            count_q  <= 32'd0;
            wrap_q   <= 1'b0;
            presc_q  <= '0;
            enable_q <= 1'b0;
            val_q    <= 4'hF;
            sidx_q   <= 3'd7;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            stab_q   <= stab_d;
            inc_q    <= inc_d;
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            presc_q  <= presc_d;
            enable_q <= enable_d;
            val_q    <= val_d;
            sidx_q   <= sidx_d;
        end
    end

    assign enable     = enable_q;
    assign val        = val_q;
    assign sidx       = sidx_q;
    assign count_wrap = wrap_q;

endmodule
